serial_subtractor: RTL and testbench

Multi-cycle, parametrised unsigned subtractor computing `Diff = A - B - Bin` over `WIDTH/DIGIT` clock cycles, `DIGIT` bits per cycle, with the borrow carried in a register between slices. It generalises the single-bit combinational half subtractor to arbitrary width, adds a borrow-in for multi-word chaining, and adds a zero flag. It uses valid/ready handshakes on both sides, so it drops into streaming datapaths where area matters more than throughput.

---
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: Diff = A - B - Bin over WIDTH/DIGIT cycles,
// with valid/ready handshakes on both sides and a registered borrow chain.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Zero
);

  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, dw_q, dw_d, diff_q, diff_d;
  logic               br_q, br_d, borrow_q, borrow_d, zero_q, zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT:0]     slice, br_ext;
  logic [WIDTH-1:0]   dw_shift;

  always_comb begin
    // The DIGIT+1-bit slice result carries the borrow-out in its top bit.
    br_ext   = {{DIGIT{1'b0}}, br_q};
    slice    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - br_ext;
    dw_shift = (dw_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dw_d     = dw_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        dw_d  = dw_shift;
        br_d  = slice[DIGIT];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          diff_d   = dw_shift;
          borrow_d = slice[DIGIT];
          zero_d   = (dw_shift == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dw_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dw_q     <= dw_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Diff      = diff_q;
  assign Borrow    = borrow_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three instances (8/1, 8/4, and a
// second 8/1 used as the high word of a chained 16-bit subtraction).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid [3];
  logic       in_ready [3];
  logic [7:0] a_i      [3];
  logic [7:0] b_i      [3];
  logic       bin_i    [3];
  logic       out_valid[3];
  logic       out_ready[3];
  logic [7:0] diff_o   [3];
  logic       borrow_o [3];
  logic       zero_o   [3];

  int checks = 0;
  int errors = 0;

  logic [9:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(a_i[0]), .B(b_i[0]), .Bin(bin_i[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .Diff(diff_o[0]), .Borrow(borrow_o[0]), .Zero(zero_o[0]));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(a_i[1]), .B(b_i[1]), .Bin(bin_i[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .Diff(diff_o[1]), .Borrow(borrow_o[1]), .Zero(zero_o[1]));

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .A(a_i[2]), .B(b_i[2]), .Bin(bin_i[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .Diff(diff_o[2]), .Borrow(borrow_o[2]), .Zero(zero_o[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int u, input logic [9:0] e);
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic bit pop_exp(input int u, output logic [9:0] e);
    e = '0;
    case (u)
      0: begin if (q0.size() == 0) return 1'b0; e = q0.pop_front(); end
      1: begin if (q1.size() == 0) return 1'b0; e = q1.pop_front(); end
      default: begin if (q2.size() == 0) return 1'b0; e = q2.pop_front(); end
    endcase
    return 1'b1;
  endfunction

  // Monitors: compare on every output handshake against the queued expectation.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : mon
      logic [9:0] e, act;
      forever begin
        @(negedge clk);
        if (!rst && out_valid[g] && out_ready[g]) begin
          act = {diff_o[g], borrow_o[g], zero_o[g]};
          checks++;
          if (!pop_exp(g, e)) begin
            errors++;
            $display("FAIL unexpected_result unit=%0d actual=%0h required=none", g, act);
          end else if (act !== e) begin
            errors++;
            $display("FAIL result unit=%0d actual{diff,borrow,zero}=%0h required=%0h", g, act, e);
          end
        end
      end
    end
  end

  // Caller is positioned just after a rising edge; returns just after the accept edge.
  task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit push, input logic [7:0] ed, input logic eb, input logic ez);
    int n = 0;
    if (push) push_exp(u, {ed, eb, ez});
    a_i[u] = a; b_i[u] = b; bin_i[u] = bin; in_valid[u] = 1'b1;
    while (!in_ready[u] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, input int exp_lat, input string name);
    int n = 0;
    while (!out_valid[u] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo_diff;
    logic       lo_b;
    int         seen;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; a_i[i] = '0; b_i[i] = '0; bin_i[i] = 1'b0; out_ready[i] = 1'b1;
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_outputs", {22'd0, diff_o[0], borrow_o[0], zero_o[0]}, 32'd0);
    chk("rst_in_ready_d4", 32'(in_ready[1]), 32'd1);

    issue(0, 8'h05, 8'h03, 1'b0, 1, 8'h02, 1'b0, 1'b0);
    wait_valid(0, 8, "lat_d1");
    @(posedge clk); #1;
    issue(0, 8'h03, 8'h05, 1'b0, 1, 8'hFE, 1'b1, 1'b0);
    wait_valid(0, 8, "lat_wrap");
    @(posedge clk); #1;
    issue(0, 8'h00, 8'h00, 1'b1, 1, 8'hFF, 1'b1, 1'b0);
    wait_valid(0, 8, "lat_bin");
    @(posedge clk); #1;

    issue(1, 8'hA5, 8'hA5, 1'b0, 1, 8'h00, 1'b0, 1'b1);
    wait_valid(1, 2, "lat_d4");
    @(posedge clk); #1;

    // Backpressure with new operands waiting at the input.
    out_ready[0] = 1'b0;
    issue(0, 8'h20, 8'h01, 1'b0, 1, 8'h1F, 1'b0, 1'b0);
    wait_valid(0, 8, "lat_bp");
    a_i[0] = 8'h44; b_i[0] = 8'h11; bin_i[0] = 1'b0; in_valid[0] = 1'b1;
    push_exp(0, {8'h33, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_diff_hold", 32'(diff_o[0]), 32'h1F);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 32'(in_ready[0]), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_accepted", 32'(in_ready[0]), 32'd0);
    wait_valid(0, 8, "lat_bp2");
    @(posedge clk); #1;

    // Reset four cycles into RUN.
    issue(0, 8'h50, 8'h10, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_outputs", {22'd0, diff_o[0], borrow_o[0], zero_o[0]}, 32'd0);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid[0]) seen++; end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);
    issue(0, 8'h10, 8'h01, 1'b0, 1, 8'h0F, 1'b0, 1'b0);
    wait_valid(0, 8, "lat_after_rst");
    @(posedge clk); #1;

    // 16-bit chain: 0x0100 - 0x0001.
    issue(0, 8'h00, 8'h01, 1'b0, 1, 8'hFF, 1'b1, 1'b0);
    wait_valid(0, 8, "lat_chain_lo");
    lo_diff = diff_o[0];
    lo_b    = borrow_o[0];
    chk("chain_lo_borrow", 32'(lo_b), 32'd1);
    @(posedge clk); #1;
    issue(2, 8'h01, 8'h00, lo_b, 1, 8'h00, 1'b0, 1'b1);
    wait_valid(2, 8, "lat_chain_hi");
    chk("chain_combined", {16'd0, diff_o[2], lo_diff}, 32'h00FF);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
